// File: rtl/vc_fifo_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// vc_fifo_arbiter_pkg
// Shared definitions for the virtual-channel FIFO arbiter:
//   DATA_W  - width of one packet word
//   NUM_VC  - number of virtual channels
//   IDX_W   - width of a VC index
//   link_state_e - one-hot link-FSM state encodings seen on the 'state' input
// ---------------------------------------------------------------------------
package vc_fifo_arbiter_pkg;

  localparam int DATA_W = 12;
  localparam int NUM_VC = 4;
  localparam int IDX_W  = $clog2(NUM_VC);

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } link_state_e;

endpackage

// File: rtl/vc_fifo_arbiter_fifo.sv
// ---------------------------------------------------------------------------
// vc_fifo
// Synchronous FIFO for a single virtual channel. The head word is presented
// combinationally from the read pointer so the arbiter can register it on the
// same edge that pops it.
// Ports:
//   clk          - rising-edge clock
//   reset        - asynchronous active-high reset, clears pointers and count
//   flush        - synchronous clear; overrides push and pop on that edge
//   push         - write data_in (ignored while full or flushing)
//   pop          - advance the read pointer (ignored while empty or flushing)
//   data_in      - write data
//   head         - word at the read pointer
//   count        - number of stored words (0..DEPTH)
//   full         - count == DEPTH
//   empty        - count == 0
//   almost_full  - count >= AF_THRESH
// ---------------------------------------------------------------------------
module vc_fifo
  import vc_fifo_arbiter_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              almost_full
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  // Status comes only from the registered count, so a push on this edge never
  // makes the FIFO look non-empty to the arbiter until the next cycle.
  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CNT_W'(AF_THRESH));
  assign count       = count_q;
  assign head        = mem[rd_ptr_q];

  // A push while full is dropped even when a pop frees a slot on the same edge.
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale entries are never visible past the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= data_in;
  end

endmodule

// File: rtl/vc_fifo_arbiter.sv
// ---------------------------------------------------------------------------
// vc_fifo_arbiter
// Buffers packet words for four virtual channels and pops at most one word per
// cycle, round-robin, onto p0..p3 with a one-hot (or idle) valid strobe.
// Ports:
//   clk            - rising-edge clock
//   reset          - asynchronous active-high reset, clears all state
//   state          - one-hot link state; RESET flushes, ACTIVE enables popping
//   push           - per-VC write strobe for data_in0..3
//   data_in0..3    - write data for VC0..VC3
//   p0..p3         - registered last-popped word of each VC
//   valid0..3      - one-cycle pop strobe, at most one set per cycle
//   full / empty / almost_full - per-VC FIFO status
//   overflow       - sticky per-VC flag: a push arrived while that FIFO was full
// ---------------------------------------------------------------------------
module vc_fifo_arbiter
  import vc_fifo_arbiter_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        state,
  input  logic [NUM_VC-1:0] push,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  output logic [DATA_W-1:0] p0,
  output logic [DATA_W-1:0] p1,
  output logic [DATA_W-1:0] p2,
  output logic [DATA_W-1:0] p3,
  output logic              valid0,
  output logic              valid1,
  output logic              valid2,
  output logic              valid3,
  output logic [NUM_VC-1:0] full,
  output logic [NUM_VC-1:0] empty,
  output logic [NUM_VC-1:0] almost_full,
  output logic [NUM_VC-1:0] overflow
);

  logic [DATA_W-1:0] data_in_arr [NUM_VC];
  logic [DATA_W-1:0] head        [NUM_VC];
  logic [CNT_W-1:0]  count       [NUM_VC];
  logic [DATA_W-1:0] p_q         [NUM_VC];
  logic [DATA_W-1:0] p_d         [NUM_VC];
  logic [NUM_VC-1:0] valid_q, valid_d;
  logic [NUM_VC-1:0] overflow_q, overflow_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [NUM_VC-1:0] grant_oh;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_any;
  logic              flush;
  logic              active;

  assign flush  = (state == ST_RESET);
  assign active = (state == ST_ACTIVE);

  assign data_in_arr[0] = data_in0;
  assign data_in_arr[1] = data_in1;
  assign data_in_arr[2] = data_in2;
  assign data_in_arr[3] = data_in3;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    vc_fifo #(
      .DEPTH     (DEPTH),
      .AF_THRESH (AF_THRESH)
    ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .push        (push[i]),
      .pop         (grant_oh[i]),
      .data_in     (data_in_arr[i]),
      .head        (head[i]),
      .count       (count[i]),
      .full        (full[i]),
      .empty       (empty[i]),
      .almost_full (almost_full[i])
    );
  end

  // Round-robin search starting just after the last granted VC. Offset NUM_VC
  // wraps back to last_q itself, so a lone busy VC can be granted every cycle.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand      = '0;
    grant_oh  = '0;
    grant_idx = last_q;
    grant_any = 1'b0;
    if (active) begin
      for (int k = 1; k <= NUM_VC; k++) begin
        cand = last_q + IDX_W'(k);
        if (!grant_any && (count[cand] != '0)) begin
          grant_any      = 1'b1;
          grant_idx      = cand;
          grant_oh[cand] = 1'b1;
        end
      end
    end
  end

  // Flush mirrors reset except that overflow history survives it.
  always_comb begin
    for (int i = 0; i < NUM_VC; i++) p_d[i] = p_q[i];
    valid_d    = '0;
    last_d     = last_q;
    overflow_d = overflow_q;
    if (flush) begin
      for (int i = 0; i < NUM_VC; i++) p_d[i] = '0;
      last_d = IDX_W'(NUM_VC - 1);
    end else begin
      overflow_d = overflow_q | (push & full);
      if (grant_any) begin
        p_d[grant_idx] = head[grant_idx];
        valid_d        = grant_oh;
        last_d         = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_VC; i++) p_q[i] <= '0;
      valid_q    <= '0;
      overflow_q <= '0;
      last_q     <= IDX_W'(NUM_VC - 1);
    end else begin
      for (int i = 0; i < NUM_VC; i++) p_q[i] <= p_d[i];
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      last_q     <= last_d;
    end
  end

  assign p0       = p_q[0];
  assign p1       = p_q[1];
  assign p2       = p_q[2];
  assign p3       = p_q[3];
  assign valid0   = valid_q[0];
  assign valid1   = valid_q[1];
  assign valid2   = valid_q[2];
  assign valid3   = valid_q[3];
  assign overflow = overflow_q;

endmodule

// File: tb/tb_vc_fifo_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vc_fifo_arbiter
// Self-checking bench for vc_fifo_arbiter. A queue-based reference model of
// the four channels tracks expected outputs cycle by cycle; directed sequences
// add fixed expectations for the single-VC, round-robin, full/overflow,
// flush, state-gating and mid-stream reset cases, then a random phase runs.
// ---------------------------------------------------------------------------
module tb_vc_fifo_arbiter;
  import vc_fifo_arbiter_pkg::*;

  localparam int DEPTH = 8;
  localparam int AF    = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  stateIn;
  logic [3:0]  pushIn;
  logic [11:0] dataIn [4];

  wire  [11:0] p0, p1, p2, p3;
  wire         valid0, valid1, valid2, valid3;
  wire  [3:0]  full, empty, almostFull, overflow;

  logic [11:0] pOut [4];
  logic [3:0]  validVec;

  // reference model state
  logic [11:0] mq [4][$];
  logic [11:0] mp [4];
  logic [3:0]  mvalid;
  logic [3:0]  movf;
  int          mrr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  st;
    logic [3:0]  push;
    logic [11:0] din;
    logic [3:0]  expValid;
    logic [11:0] expP2;
    logic [3:0]  expEmpty;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  always_comb begin
    pOut[0]  = p0;
    pOut[1]  = p1;
    pOut[2]  = p2;
    pOut[3]  = p3;
    validVec = {valid3, valid2, valid1, valid0};
  end

  vc_fifo_arbiter #(.DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .clk         (clk),
    .reset       (reset),
    .state       (stateIn),
    .push        (pushIn),
    .data_in0    (dataIn[0]),
    .data_in1    (dataIn[1]),
    .data_in2    (dataIn[2]),
    .data_in3    (dataIn[3]),
    .p0          (p0),
    .p1          (p1),
    .p2          (p2),
    .p3          (p3),
    .valid0      (valid0),
    .valid1      (valid1),
    .valid2      (valid2),
    .valid3      (valid3),
    .full        (full),
    .empty       (empty),
    .almost_full (almostFull),
    .overflow    (overflow)
  );

  task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      mp[i] = '0;
    end
    mvalid = '0;
    movf   = '0;
    mrr    = 3;
  endtask

  // One clock edge of the channel rules, using pre-edge occupancy for both
  // eligibility and the full test.
  task automatic modelStep();
    int sz [4];
    bit granted;
    for (int i = 0; i < 4; i++) sz[i] = mq[i].size();
    mvalid = '0;
    if (stateIn == ST_RESET) begin
      for (int i = 0; i < 4; i++) begin
        mq[i].delete();
        mp[i] = '0;
      end
      mrr = 3;
      return;
    end
    granted = 1'b0;
    if (stateIn == ST_ACTIVE) begin
      for (int k = 1; k <= 4; k++) begin
        int g;
        g = (mrr + k) % 4;
        if (!granted && sz[g] > 0) begin
          mp[g]     = mq[g].pop_front();
          mvalid[g] = 1'b1;
          mrr       = g;
          granted   = 1'b1;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (pushIn[i]) begin
        if (sz[i] >= DEPTH) movf[i] = 1'b1;
        else mq[i].push_back(dataIn[i]);
      end
    end
  endtask

  task automatic applyStimulus(input logic [3:0] st, input logic [3:0] ps,
                               input logic [11:0] d0, input logic [11:0] d1,
                               input logic [11:0] d2, input logic [11:0] d3);
    stateIn   = st;
    pushIn    = ps;
    dataIn[0] = d0;
    dataIn[1] = d1;
    dataIn[2] = d2;
    dataIn[3] = d3;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkOutput();
    logic [3:0] mf, me, ma;
    for (int i = 0; i < 4; i++) begin
      mf[i] = (mq[i].size() == DEPTH);
      me[i] = (mq[i].size() == 0);
      ma[i] = (mq[i].size() >= AF);
    end
    expectEq("valid", validVec, mvalid);
    expectEq("onehot0", $onehot0(validVec), 1);
    for (int i = 0; i < 4; i++) expectEq($sformatf("p%0d", i), pOut[i], mp[i]);
    expectEq("full", full, mf);
    expectEq("empty", empty, me);
    expectEq("almost_full", almostFull, ma);
    expectEq("overflow", overflow, movf);
  endtask

  task automatic tick(input logic [3:0] st, input logic [3:0] ps,
                      input logic [11:0] d0, input logic [11:0] d1,
                      input logic [11:0] d2, input logic [11:0] d3);
    applyStimulus(st, ps, d0, d1, d2, d3);
    checkOutput();
  endtask

  task automatic tickAll(input logic [3:0] st, input logic [3:0] ps, input logic [11:0] d);
    tick(st, ps, d, d, d, d);
  endtask

  task automatic checkResetValues(input string tag);
    expectEq({tag, ".valid"}, validVec, 4'h0);
    for (int i = 0; i < 4; i++) expectEq($sformatf("%s.p%0d", tag, i), pOut[i], 12'h000);
    expectEq({tag, ".empty"}, empty, 4'hF);
    expectEq({tag, ".full"}, full, 4'h0);
    expectEq({tag, ".almost_full"}, almostFull, 4'h0);
    expectEq({tag, ".overflow"}, overflow, 4'h0);
  endtask

  initial begin
    int expVc [4];
    logic [11:0] expW [4];

    vecs[0] = '{ST_ACTIVE, 4'b0100, 12'hA01, 4'b0000, 12'h000, 4'b1011};
    vecs[1] = '{ST_ACTIVE, 4'b0100, 12'hA02, 4'b0100, 12'hA01, 4'b1011};
    vecs[2] = '{ST_ACTIVE, 4'b0100, 12'hA03, 4'b0100, 12'hA02, 4'b1011};
    vecs[3] = '{ST_ACTIVE, 4'b0000, 12'h000, 4'b0100, 12'hA03, 4'b1111};
    vecs[4] = '{ST_ACTIVE, 4'b0000, 12'h000, 4'b0000, 12'hA03, 4'b1111};

    // power-on reset
    reset   = 1'b1;
    stateIn = ST_IDLE;
    pushIn  = '0;
    for (int i = 0; i < 4; i++) dataIn[i] = '0;
    modelReset();
    #12;
    checkResetValues("por");
    @(negedge clk);
    reset = 1'b0;

    // single VC, back-to-back pushes
    $display("[TB] single VC table");
    for (int v = 0; v < 5; v++) begin
      tickAll(vecs[v].st, vecs[v].push, vecs[v].din);
      expectEq($sformatf("single[%0d].valid", v), validVec, vecs[v].expValid);
      expectEq($sformatf("single[%0d].p2", v), pOut[2], vecs[v].expP2);
      expectEq($sformatf("single[%0d].empty", v), empty, vecs[v].expEmpty);
    end

    // round robin over preloaded channels
    $display("[TB] round robin");
    tickAll(ST_RESET, 4'h0, 12'h000);
    for (int j = 0; j < 2; j++)
      tick(ST_IDLE, 4'hF, 12'(j), 12'(16 + j), 12'(32 + j), 12'(48 + j));
    for (int k = 0; k < 8; k++) begin
      tickAll(ST_ACTIVE, 4'h0, 12'h000);
      expectEq($sformatf("rr[%0d].valid", k), validVec, 32'(1 << (k % 4)));
      expectEq($sformatf("rr[%0d].data", k), pOut[k % 4], 32'((k % 4) * 16 + k / 4));
    end
    tickAll(ST_ACTIVE, 4'h0, 12'h000);
    expectEq("rr.drained", validVec, 4'h0);

    // full / almost_full / overflow on VC1
    $display("[TB] full and overflow");
    tickAll(ST_RESET, 4'h0, 12'h000);
    for (int n = 1; n <= 9; n++) begin
      tickAll(ST_IDLE, 4'b0010, 12'(12'h100 + n));
      expectEq($sformatf("fill[%0d].af1", n), almostFull[1], n >= 6);
      expectEq($sformatf("fill[%0d].full1", n), full[1], n >= 8);
      expectEq($sformatf("fill[%0d].ovf1", n), overflow[1], n == 9);
    end
    for (int n = 1; n <= 9; n++) begin
      tickAll(ST_ACTIVE, 4'h0, 12'h000);
      if (n <= 8) begin
        expectEq($sformatf("drain[%0d].valid", n), validVec, 4'b0010);
        expectEq($sformatf("drain[%0d].p1", n), pOut[1], 32'(12'h100 + n));
      end else begin
        expectEq("drain.end", validVec, 4'h0);
      end
    end

    // flush keeps overflow, empties VC3
    $display("[TB] flush");
    for (int n = 0; n < 5; n++) tickAll(ST_IDLE, 4'b1000, 12'(12'h300 + n));
    expectEq("flush.pre_empty3", empty[3], 1'b0);
    tickAll(ST_RESET, 4'b1000, 12'hBAD);
    expectEq("flush.empty", empty, 4'hF);
    expectEq("flush.ovf1", overflow[1], 1'b1);
    expectEq("flush.valid", validVec, 4'h0);
    tickAll(ST_ACTIVE, 4'h0, 12'h000);
    expectEq("flush.no_valid3", validVec, 4'h0);

    // state gating mid-stream
    $display("[TB] state gating");
    for (int j = 0; j < 3; j++)
      tick(ST_IDLE, 4'b0101, 12'(12'h600 + j), 12'h000, 12'(12'h620 + j), 12'h000);
    tickAll(ST_ACTIVE, 4'h0, 12'h000);
    expectEq("gate.g0.valid", validVec, 4'b0001);
    expectEq("gate.g0.p0", pOut[0], 12'h600);
    tickAll(ST_ACTIVE, 4'h0, 12'h000);
    expectEq("gate.g1.valid", validVec, 4'b0100);
    expectEq("gate.g1.p2", pOut[2], 12'h620);
    for (int c = 0; c < 2; c++) begin
      tickAll(ST_IDLE, 4'h0, 12'h000);
      expectEq($sformatf("gate.idle[%0d]", c), validVec, 4'h0);
    end
    expVc = '{0, 2, 0, 2};
    expW  = '{12'h601, 12'h621, 12'h602, 12'h622};
    for (int c = 0; c < 4; c++) begin
      tickAll(ST_ACTIVE, 4'h0, 12'h000);
      expectEq($sformatf("gate.resume[%0d].valid", c), validVec, 32'(1 << expVc[c]));
      expectEq($sformatf("gate.resume[%0d].data", c), pOut[expVc[c]], expW[c]);
    end
    tickAll(ST_ACTIVE, 4'h0, 12'h000);
    expectEq("gate.drained", validVec, 4'h0);

    // asynchronous reset mid-stream
    $display("[TB] mid-stream reset");
    tick(ST_IDLE, 4'hF, 12'h700, 12'h710, 12'h720, 12'h730);
    tick(ST_IDLE, 4'hF, 12'h701, 12'h711, 12'h721, 12'h731);
    tickAll(ST_ACTIVE, 4'h0, 12'h000);
    reset = 1'b1;
    modelReset();
    #2;
    checkResetValues("midrst");
    @(negedge clk);
    reset = 1'b0;
    tick(ST_IDLE, 4'b0011, 12'h801, 12'h811, 12'h000, 12'h000);
    tickAll(ST_ACTIVE, 4'h0, 12'h000);
    expectEq("midrst.first_grant", validVec, 4'b0001);
    expectEq("midrst.first_data", pOut[0], 12'h801);

    // randomized traffic against the model
    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      int r;
      logic [3:0] st;
      r = int'($urandom_range(0, 31));
      if (r == 0) st = ST_RESET;
      else if (r <= 7) st = ST_IDLE;
      else if (r == 8) st = ST_INIT;
      else st = ST_ACTIVE;
      if (c % 700 == 350) begin
        reset = 1'b1;
        modelReset();
        #2;
        checkResetValues("rndrst");
        @(negedge clk);
        reset = 1'b0;
      end
      tick(st, 4'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
